// File: rtl/vga_out_pkg.sv
// Shared types, dither table and pin packing for the VGA PMOD output stage.
package vga_out_pkg;

  typedef enum logic {
    PIN_TT  = 1'b0,
    PIN_ALT = 1'b1
  } pinout_e;

  // 2x2 ordered-dither thresholds indexed by {row parity, col[0]}: {0,2;3,1}
  localparam logic [3:0][1:0] BAYER = {2'd1, 2'd3, 2'd2, 2'd0};

  function automatic logic [7:0] pack_pins(input pinout_e    pin,
                                           input logic       hs,
                                           input logic       vs,
                                           input logic [1:0] r,
                                           input logic [1:0] g,
                                           input logic [1:0] b);
    if (pin == PIN_ALT) begin
      return {b[0], b[1], g[0], g[1], r[0], r[1], vs, hs};
    end
    return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  endfunction

endpackage

// File: rtl/vga_dither_reduce.sv
// Reduces one CBITS-wide colour channel to 2 bits, optionally adding an ordered-dither
// threshold before truncation and saturating at 3.
module vga_dither_reduce #(
  parameter int unsigned CBITS = 2
) (
  input  logic [CBITS-1:0] i_v,
  input  logic             i_dither,
  input  logic [1:0]       i_bayer,
  output logic [1:0]       o_v
);

  if (CBITS == 2) begin : g_pass
    logic w_unused;
    assign w_unused = ^{i_dither, i_bayer};
    assign o_v      = i_v;
  end else begin : g_reduce
    localparam int unsigned SH = CBITS - 2;

    // One extra bit so v + t cannot wrap before the saturation test
    logic [CBITS:0] w_t;
    logic [CBITS:0] w_sum;
    logic [CBITS:0] w_q;

    assign w_t   = i_dither ? ((((CBITS + 1)'(i_bayer)) << SH) >> 2) : '0;
    assign w_sum = {1'b0, i_v} + w_t;
    assign w_q   = w_sum >> SH;
    assign o_v   = (w_q > (CBITS + 1)'(3)) ? 2'd3 : w_q[1:0];
  end

endmodule

// File: rtl/vga_pmod_out.sv
// Registered VGA pin driver: frame-aligned mode latch, colour-bar pattern, dither/reduction,
// blank masking and a PIPE-deep output pipeline shared by sync and colour.
module vga_pmod_out
  import vga_out_pkg::*;
#(
  parameter int unsigned CBITS         = 2,
  parameter int unsigned PIPE          = 1,
  parameter int unsigned BAR_W         = 80,
  parameter bit          VSYNC_ACT_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               blank_in,
  input  logic [3*CBITS-1:0] rgb_in,
  input  logic [1:0]         mode_in,
  input  logic               dither_en,
  output logic [7:0]         uo_out,
  output logic               frame_strobe,
  output logic [1:0]         mode_q
);

  localparam int unsigned PERIOD = 8 * BAR_W;
  localparam int unsigned COL_W  = $clog2(PERIOD);

  logic             r_vs_prev;
  logic             r_blank_prev;
  logic             r_row;
  logic             r_dither_q;
  logic             r_strobe;
  logic [1:0]       r_mode_q;
  logic [COL_W-1:0] r_col;
  logic [7:0]       r_pipe [PIPE];

  logic             w_vs_act;
  logic             w_vs_prev_act;
  logic             w_fs;
  logic             w_line_end;
  logic [2:0]       w_bar;
  logic [1:0]       w_bayer;
  logic [CBITS-1:0] w_chan [3];
  logic [1:0]       w_red  [3];
  logic [1:0]       w_mask [3];
  logic [7:0]       w_pins;

  assign w_vs_act      = VSYNC_ACT_LOW ? ~vsync_in : vsync_in;
  assign w_vs_prev_act = VSYNC_ACT_LOW ? ~r_vs_prev : r_vs_prev;
  assign w_fs          = w_vs_act & ~w_vs_prev_act;
  assign w_line_end    = blank_in & ~r_blank_prev;
  assign w_bar         = 3'(r_col / COL_W'(BAR_W));
  assign w_bayer       = BAYER[{r_row, r_col[0]}];

  // Channel index 0 = B, 1 = G, 2 = R, matching bar index bits b[0..2]
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_chan[i] = r_mode_q[1] ? {CBITS{w_bar[i]}} : rgb_in[i*CBITS +: CBITS];
      w_mask[i] = blank_in ? 2'b00 : w_red[i];
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_chan
    vga_dither_reduce #(
      .CBITS(CBITS)
    ) u_reduce (
      .i_v     (w_chan[i]),
      .i_dither(r_dither_q),
      .i_bayer (w_bayer),
      .o_v     (w_red[i])
    );
  end

  assign w_pins = pack_pins(pinout_e'(r_mode_q[0]), hsync_in, vsync_in,
                            w_mask[2], w_mask[1], w_mask[0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vs_prev    <= 1'b0;
      r_blank_prev <= 1'b0;
      r_row        <= 1'b0;
      r_dither_q   <= 1'b0;
      r_strobe     <= 1'b0;
      r_mode_q     <= 2'b00;
      r_col        <= '0;
    end else begin
      r_vs_prev    <= vsync_in;
      r_blank_prev <= blank_in;
      r_strobe     <= w_fs;
      if (w_fs) begin
        r_mode_q   <= mode_in;
        r_dither_q <= dither_en;
      end
      if (blank_in || (r_col == COL_W'(PERIOD - 1))) begin
        r_col <= '0;
      end else begin
        r_col <= r_col + 1'b1;
      end
      if (w_fs) begin
        r_row <= 1'b0;
      end else if (w_line_end) begin
        r_row <= ~r_row;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE; i++) begin
        r_pipe[i] <= 8'h00;
      end
    end else begin
      r_pipe[0] <= w_pins;
      for (int i = 1; i < PIPE; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign uo_out       = r_pipe[PIPE-1];
  assign frame_strobe = r_strobe;
  assign mode_q       = r_mode_q;

endmodule

// File: tb/tb_vga_pmod_out.sv
// Randomised scoreboard bench for vga_pmod_out with an arithmetic reference model.
module tb_vga_pmod_out;

  localparam int CB     = 4;
  localparam int PIPE_N = 2;
  localparam int BW     = 4;
  localparam bit VAL    = 1'b1;
  localparam int BAY [2][2] = '{'{0, 2}, '{3, 1}};

  logic          clk = 1'b0;
  logic          reset;
  logic          hsync_in, vsync_in, blank_in, dither_en;
  logic [3*CB-1:0] rgb_in;
  logic [1:0]    mode_in;
  logic [7:0]    uo_out;
  logic          frame_strobe;
  logic [1:0]    mode_q;

  vga_pmod_out #(
    .CBITS(CB),
    .PIPE(PIPE_N),
    .BAR_W(BW),
    .VSYNC_ACT_LOW(VAL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .blank_in    (blank_in),
    .rgb_in      (rgb_in),
    .mode_in     (mode_in),
    .dither_en   (dither_en),
    .uo_out      (uo_out),
    .frame_strobe(frame_strobe),
    .mode_q      (mode_q)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [7:0] pins; } pin_t;
  typedef struct { int due; logic [1:0] mode; logic strobe; } ctl_t;

  pin_t qp[$];
  ctl_t qc[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int         m_pos;
  bit         m_row, m_vs_prev, m_blank_prev, m_dith;
  logic [1:0] m_mode;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_row = 0; m_vs_prev = 0; m_blank_prev = 0; m_dith = 0; m_mode = 2'b00;
  endtask

  function automatic bit asserted(input bit vs);
    return VAL ? !vs : vs;
  endfunction

  function automatic int reduce(input int v, input int row, input int c0, input bit dith);
    int sh, t, s;
    sh = CB - 2;
    t  = dith ? (BAY[row][c0] * (1 << sh)) / 4 : 0;
    s  = (v + t) >> sh;
    return (s > 3) ? 3 : s;
  endfunction

  function automatic logic [7:0] exp_pins(input logic hs, input logic vs, input logic blank,
                                          input logic [3*CB-1:0] rgb);
    int col, bar, v;
    int ch [3];
    logic [1:0] r, g, b;
    col = m_pos % (8 * BW);
    bar = col / BW;
    for (int c = 0; c < 3; c++) begin
      if (m_mode[1]) v = ((bar >> c) & 1) ? (1 << CB) - 1 : 0;
      else v = int'(rgb[c*CB +: CB]);
      ch[c] = blank ? 0 : reduce(v, int'(m_row), col % 2, m_dith);
    end
    b = 2'(ch[0]); g = 2'(ch[1]); r = 2'(ch[2]);
    if (m_mode[0]) return {b[0], b[1], g[0], g[1], r[0], r[1], vs, hs};
    return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  endfunction

  // One pixel clock of stimulus; expected responses go to the scoreboard queues
  task automatic drive(input logic hs, input logic vs, input logic blank,
                       input logic [3*CB-1:0] rgb, input logic [1:0] mode, input logic dith);
    bit fs;
    @(negedge clk);
    hsync_in = hs; vsync_in = vs; blank_in = blank; rgb_in = rgb; mode_in = mode; dither_en = dith;
    qp.push_back('{due: cyc + PIPE_N, pins: exp_pins(hs, vs, blank, rgb)});
    fs = asserted(vs) && !asserted(m_vs_prev);
    if (fs) begin
      m_mode = mode;
      m_dith = dith;
    end
    qc.push_back('{due: cyc + 1, mode: m_mode, strobe: fs});
    if (fs) m_row = 0;
    else if (blank && !m_blank_prev) m_row = !m_row;
    m_pos = blank ? 0 : m_pos + 1;
    m_vs_prev = vs;
    m_blank_prev = blank;
  endtask

  task automatic rand_line(input bit vpulse);
    int nb, na;
    nb = $urandom_range(3, 6);
    na = $urandom_range(5, 40);
    for (int i = 0; i < nb; i++)
      drive(1'($urandom), (vpulse && i >= 1 && i <= 2) ? 1'b0 : 1'b1, 1'b1,
            12'($urandom), 2'($urandom), 1'($urandom));
    for (int i = 0; i < na; i++)
      drive(1'($urandom), 1'b1, 1'b0, 12'($urandom), 2'($urandom), 1'($urandom));
  endtask

  // Monitor: compares DUT outputs against queued expectations as they come due
  initial begin
    pin_t p;
    ctl_t c;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (reset) begin
        chk("reset_uo_out", uo_out, 8'h00);
        chk("reset_mode_q", {6'b0, mode_q}, 8'h00);
        chk("reset_strobe", {7'b0, frame_strobe}, 8'h00);
      end else begin
        while (qp.size() > 0 && qp[0].due <= cyc) begin
          p = qp.pop_front();
          chk("uo_out", uo_out, p.pins);
        end
        while (qc.size() > 0 && qc[0].due <= cyc) begin
          c = qc.pop_front();
          chk("mode_q", {6'b0, mode_q}, {6'b0, c.mode});
          chk("frame_strobe", {7'b0, frame_strobe}, {7'b0, c.strobe});
        end
      end
    end
  end

  localparam logic [11:0] RGB_T2 = 12'h84C;  // R=10xx G=01xx B=11xx

  initial begin
    reset = 1'b0;
    hsync_in = 0; vsync_in = 1; blank_in = 1; rgb_in = '0; mode_in = 0; dither_en = 0;
    #1 reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      hsync_in = 1'($urandom); vsync_in = 1'($urandom); blank_in = 1'($urandom);
      rgb_in = 12'($urandom); mode_in = 2'($urandom); dither_en = 1'($urandom);
    end
    @(posedge clk); #3;
    reset = 1'b0;
    model_reset();

    // No frame start: mode must stay 0 whatever mode_in does
    repeat (20) drive(1'($urandom), 1'b1, 1'($urandom), 12'($urandom), 2'($urandom), 1'($urandom));

    // Fixed colour in mode 0, then mode_in=1 mid-frame, then frame start applies it
    drive(1, 1, 1, 12'h000, 2'b00, 0);
    drive(1, 0, 1, 12'h000, 2'b00, 0);
    repeat (3) drive(1, 0, 0, RGB_T2, 2'b00, 0);
    repeat (5) drive(1, 1, 0, RGB_T2, 2'b01, 0);
    drive(1, 0, 0, RGB_T2, 2'b01, 0);
    repeat (3) drive(1, 0, 0, RGB_T2, 2'b01, 0);

    // Colour bars: 40 pixels crosses the 32-pixel wrap
    drive(0, 1, 1, 12'h000, 2'b10, 0);
    drive(0, 0, 1, 12'h000, 2'b10, 0);
    repeat (3) drive(0, 1, 1, 12'($urandom), 2'b10, 0);
    repeat (40) drive(0, 1, 0, 12'($urandom), 2'b10, 0);
    repeat (3) drive(0, 1, 1, 12'($urandom), 2'b10, 0);
    repeat (10) drive(0, 1, 0, 12'($urandom), 2'b10, 0);

    // Dither on mid-level and full-scale colour across both row parities
    drive(0, 1, 1, 12'h000, 2'b00, 1);
    drive(0, 0, 1, 12'h000, 2'b00, 1);
    for (int ln = 0; ln < 4; ln++) begin
      repeat (3) drive(0, 1, 1, 12'h000, 2'b00, 1);
      repeat (8) drive(1, 1, 0, (ln < 2) ? 12'h666 : 12'hFFF, 2'b00, 1);
    end

    for (int ln = 0; ln < 50; ln++) rand_line(ln % 7 == 0);

    // Reset pulse during active video
    repeat (10) drive(1'($urandom), 1'b1, 1'b0, 12'($urandom), 2'($urandom), 1'($urandom));
    #2 reset = 1'b1;
    qp.delete();
    qc.delete();
    #1;
    chk("async_reset_uo_out", uo_out, 8'h00);
    chk("async_reset_mode_q", {6'b0, mode_q}, 8'h00);
    @(posedge clk); #3;
    reset = 1'b0;
    model_reset();
    for (int ln = 0; ln < 3; ln++) rand_line(1'b0);
    for (int ln = 0; ln < 15; ln++) rand_line(ln % 4 == 0);

    repeat (PIPE_N + 2) @(negedge clk);
    total++;
    if (qp.size() != 0 || qc.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d/%0d expectations left, want 0/0", qp.size(), qc.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
